// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode classes, FSM states and control flags.
package decode_pkg;

  localparam logic [1:0] CLS_ONE = 2'b00;
  localparam logic [1:0] CLS_TWO = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_IMM = 2'b11;

  localparam logic [4:0] OPC_NOP = 5'd0;

  typedef enum logic {
    S_OP,
    S_IMM
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic imm_sel;
  } ctrl_t;

  // Opcode class, NOP detect and opcode LSB fully determine the control flags.
  function automatic ctrl_t decode_flags(input logic [1:0] cls, input logic is_nop,
                                         input logic lsb);
    ctrl_t f;
    f = '0;
    case (cls)
      CLS_ONE: f.reg_write = !is_nop;
      CLS_TWO: f.reg_write = 1'b1;
      CLS_MEM: begin
        f.reg_write = !lsb;
        f.mem_read  = !lsb;
        f.mem_write = lsb;
      end
      default: begin
        f.imm_sel   = 1'b1;
        f.reg_write = 1'b1;
        f.mem_read  = lsb;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file with two combinational read ports, writeback bypass and one write port.
module decode_regfile #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = 16,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a_c,
  output logic [DATA_W-1:0] rd_data_b_c
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: cleared on reset, written by writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reads see a same-cycle writeback to the same index.
  always_comb begin
    rd_data_a_c = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    rd_data_b_c = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: assembles one/two-word instructions, reads operands, feeds execute.
module decode_unit
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OPC_W    = 5,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_word,
  output logic               id_ready,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [OPC_W-1:0]   ex_opcode,
  output logic [AW-1:0]      ex_rd,
  output logic [DATA_W-1:0]  ex_rd_val,
  output logic [DATA_W-1:0]  ex_rs_val,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_imm_sel
);

  state_t            state, state_nxt;
  logic [OPC_W-1:0]  hold_opc;
  logic [AW-1:0]     hold_rd, hold_rs;
  logic [OPC_W-1:0]  in_opc, cur_opc;
  logic [AW-1:0]     in_rd, in_rs, cur_rd, cur_rs;
  logic [DATA_W-1:0] rd_val_c, rs_val_c, imm_c;
  logic              load, latch, ex_free;
  ctrl_t             flags_c;

  assign in_opc = if_word[INSTR_W-1 -: OPC_W];
  assign in_rd  = if_word[INSTR_W-OPC_W-1 -: AW];
  assign in_rs  = if_word[INSTR_W-OPC_W-AW-1 -: AW];

  // In S_IMM the instruction fields come from the held first word.
  always_comb begin
    cur_opc = (state == S_IMM) ? hold_opc : in_opc;
    cur_rd  = (state == S_IMM) ? hold_rd : in_rd;
    cur_rs  = (state == S_IMM) ? hold_rs : in_rs;
    imm_c   = (state == S_IMM) ? DATA_W'($signed(if_word)) : '0;
    flags_c = decode_flags(cur_opc[OPC_W-1 -: 2], cur_opc == OPC_W'(OPC_NOP), cur_opc[0]);
    ex_free = !ex_valid || ex_ready;
  end

  decode_regfile #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wb_en),
    .wr_addr    (wb_addr),
    .wr_data    (wb_data),
    .rd_addr_a  (cur_rd),
    .rd_addr_b  (cur_rs),
    .rd_data_a_c(rd_val_c),
    .rd_data_b_c(rs_val_c)
  );

  // FSM state and hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_OP;
      hold_opc <= '0;
      hold_rd  <= '0;
      hold_rs  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        hold_opc <= '0;
        hold_rd  <= '0;
        hold_rs  <= '0;
      end else if (latch) begin
        hold_opc <= in_opc;
        hold_rd  <= in_rd;
        hold_rs  <= in_rs;
      end
    end
  end

  // Next state, handshake and load/latch strobes; the hold path ignores ex stall.
  always_comb begin
    state_nxt = state;
    id_ready  = 1'b0;
    load      = 1'b0;
    latch     = 1'b0;
    if (!reset && !flush) begin
      case (state)
        S_OP: begin
          id_ready = (in_opc[OPC_W-1 -: 2] == CLS_IMM) ? 1'b1 : ex_free;
          if (if_valid && id_ready) begin
            if (in_opc[OPC_W-1 -: 2] == CLS_IMM) begin
              latch     = 1'b1;
              state_nxt = S_IMM;
            end else begin
              load = 1'b1;
            end
          end
        end
        default: begin
          id_ready = ex_free;
          if (if_valid && id_ready) begin
            load      = 1'b1;
            state_nxt = S_OP;
          end
        end
      endcase
    end
    if (flush) state_nxt = S_OP;
  end

  // Execute pipeline register: load, hold under stall, drain when consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_rd        <= '0;
      ex_rd_val    <= '0;
      ex_rs_val    <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_imm_sel   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_opcode    <= cur_opc;
      ex_rd        <= cur_rd;
      ex_rd_val    <= rd_val_c;
      ex_rs_val    <= rs_val_c;
      ex_imm       <= imm_c;
      ex_reg_write <= flags_c.reg_write;
      ex_mem_read  <= flags_c.mem_read;
      ex_mem_write <= flags_c.mem_write;
      ex_imm_sel   <= flags_c.imm_sel;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
